// File: rtl/wb_master_pkg.sv
// Shared definitions for the WISHBONE command-stream master: FSM state
// encodings and the packed command word layout {we, adr, data}.
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Width of one queued command word: {we, adr, data}, MSB first.
    function automatic int cmd_width(input int adr_width, input int data_width);
        return 1 + adr_width + data_width;
    endfunction

    // Width of the ack timeout counter; at least one bit even when the
    // timeout is disabled, so the counter always has a legal declaration.
    function automatic int cnt_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued bus commands.
// The head entry is visible on 'head' whenever 'empty' is low.
module wb_cmd_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int           PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if the head is popped at the same edge.
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, so clearing it would cost logic and buy nothing.
    // Storage write port.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_master_seq.sv
// WISHBONE classic-cycle master fed by a queued command stream. Each command
// runs one bus cycle and returns exactly one response; a programmable ack
// timeout turns a silent slave into an error response instead of a hang.
module wb_master_seq
    import wb_master_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADR_WIDTH  = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADR_WIDTH-1:0]  cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    // response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    // WISHBONE bus
    output logic                  stb,
    output logic                  we,
    output logic [ADR_WIDTH-1:0]  adr,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  ack,
    input  logic [DATA_WIDTH-1:0] din
);

    localparam int            CW          = cmd_width(ADR_WIDTH, DATA_WIDTH);
    localparam int            TW          = cnt_width(TIMEOUT);
    localparam logic [TW-1:0] CNT_MAX     = '1;
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    // Command FIFO.
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [CW-1:0]         fifo_head;
    logic                  head_we;
    logic [ADR_WIDTH-1:0]  head_adr;
    logic [DATA_WIDTH-1:0] head_data;

    wb_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_we, cmd_adr, cmd_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_we, head_adr, head_data} = fifo_head;

    // FSM state and next-state values for every registered output.
    state_t                state;
    state_t                state_n;
    logic                  stb_n;
    logic                  we_n;
    logic [ADR_WIDTH-1:0]  adr_n;
    logic [DATA_WIDTH-1:0] dout_n;
    logic                  rsp_valid_n;
    logic [DATA_WIDTH-1:0] rsp_data_n;
    logic                  rsp_err_n;
    logic [TW-1:0]         cnt;
    logic [TW-1:0]         cnt_n;
    logic [TW-1:0]         cnt_inc;
    logic                  timed_out;
    logic                  start_bus;

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    // Saturating increment; the counter never wraps back to zero.
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign timed_out = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_CNT);

    // NOTE: every variable below gets its hold value first, so no path through
    // the case leaves one unassigned and no latch can be inferred.
    // Next-state and next-output logic for the bus sequencer.
    always_comb begin
        state_n     = state;
        stb_n       = stb;
        we_n        = we;
        adr_n       = adr;
        dout_n      = dout;
        rsp_valid_n = rsp_valid;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        cnt_n       = cnt;
        fifo_pop    = 1'b0;
        start_bus   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) start_bus = 1'b1;
            end

            ST_BUS: begin
                if (ack) begin
                    // Slave answered: close the cycle and present the response.
                    state_n     = ST_RSP;
                    stb_n       = 1'b0;
                    we_n        = 1'b0;
                    adr_n       = '0;
                    dout_n      = '0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_data_n  = we ? '0 : din;
                end else begin
                    cnt_n = cnt_inc;
                    if (timed_out) begin
                        // Slave is silent: abandon the cycle with an error.
                        state_n     = ST_RSP;
                        stb_n       = 1'b0;
                        we_n        = 1'b0;
                        adr_n       = '0;
                        dout_n      = '0;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_data_n  = '0;
                    end
                end
            end

            ST_RSP: begin
                // Only one response may be outstanding; the bus waits for it.
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    rsp_data_n  = '0;
                    rsp_err_n   = 1'b0;
                    if (!fifo_empty) start_bus = 1'b1;
                    else             state_n   = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase

        // Launch the next bus cycle straight from the FIFO head.
        if (start_bus) begin
            fifo_pop = 1'b1;
            state_n  = ST_BUS;
            stb_n    = 1'b1;
            we_n     = head_we;
            adr_n    = head_adr;
            dout_n   = head_data;
            cnt_n    = '0;
        end
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others, exactly like hardware.
    // State register and registered outputs; reset discards any bus cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            stb       <= 1'b0;
            we        <= 1'b0;
            adr       <= '0;
            dout      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            stb       <= stb_n;
            we        <= we_n;
            adr       <= adr_n;
            dout      <= dout_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
            cnt       <= cnt_n;
        end
    end

endmodule
